// File: rtl/uart_tx_ctrl_if.sv
// Parallel-word / serial-line bundle for uart_tx_ctrl.
// master = word source and line observer, slave = the transmit controller.
interface uart_tx_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             TX_OUT;
  logic             BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to transmit two stop bits instead of one.
module uart_tx_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave bus
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic [CW-1:0]    cnt_q, cnt_n, cnt_inc;
  logic             par_en_q, par_en_n;
  logic             par_typ_q, par_typ_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             par_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic             stop_q, stop_n;
`endif

  assign cnt_inc    = cnt_q + CW'(1);
  assign par_bit    = par_typ_q ^ (^data_q);
  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = busy_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      cnt_q     <= cnt_n;
      par_en_q  <= par_en_n;
      par_typ_q <= par_typ_n;
      tx_q      <= tx_n;
      busy_q    <= busy_n;
`ifdef UART_TX_TWO_STOP_EN
      stop_q    <= stop_n;
`endif
    end
  end

  // Outputs are registered, so each branch computes the line level of the
  // state being entered rather than the current one.
  always_comb begin
    state_n   = state_q;
    data_n    = data_q;
    cnt_n     = cnt_q;
    par_en_n  = par_en_q;
    par_typ_n = par_typ_q;
    tx_n      = 1'b1;
    busy_n    = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
    stop_n    = stop_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.DATA_VALID) begin
          state_n   = START;
          data_n    = bus.P_DATA;
          par_en_n  = bus.PAR_EN;
          par_typ_n = bus.PAR_TYP;
          tx_n      = 1'b0;
        end else begin
          busy_n = 1'b0;
        end
      end
      START: begin
        state_n = DATA;
        cnt_n   = '0;
        tx_n    = data_q[0];
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_n = '0;
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = par_bit;
          end else begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt_inc;
          tx_n  = data_q[cnt_inc];
        end
      end
      PARITY: begin
        state_n = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (!stop_q) begin
          stop_n = 1'b1;
        end else begin
          stop_n  = 1'b0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end
`else
        state_n = IDLE;
        busy_n  = 1'b0;
`endif
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: expected frames queued at stimulus time,
// compared by a line monitor whenever BUSY drops.
module tb_uart_tx_ctrl;

  typedef struct {
    logic [31:0] bits;
    int unsigned len;
  } frame_t;

`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOPS = 2;
`else
  localparam int unsigned STOPS = 1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_ctrl_if #(.WIDTH(8)) dut_if ();

  uart_tx_ctrl #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (dut_if.slave)
  );

  int          checks = 0;
  int          errors = 0;
  frame_t      exp_q[$];
  int          frames_done = 0;
  int          frames_started = 0;
  int          last_gap = 0;
  int          idle_run = 0;
  int unsigned last_len = 0;
  bit          discard = 1'b0;
  bit          in_frame = 1'b0;
  logic [31:0] cur_bits;
  int unsigned cur_len;

  function automatic frame_t model(input logic [7:0] d, input logic en, input logic typ);
    frame_t f;
    logic   p;
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.len = 1;
    p = typ;
    for (int i = 0; i < 8; i++) begin
      f.bits[f.len] = d[i];
      p = p ^ d[i];
      f.len++;
    end
    if (en) begin
      f.bits[f.len] = p;
      f.len++;
    end
    for (int unsigned s = 0; s < STOPS; s++) begin
      f.bits[f.len] = 1'b1;
      f.len++;
    end
    return f;
  endfunction

  // Line monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (dut_if.BUSY === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          cur_bits = '0;
          cur_len  = 0;
          last_gap = idle_run;
          frames_started++;
        end
        if (cur_len < 32) cur_bits[cur_len] = dut_if.TX_OUT;
        cur_len++;
      end else begin
        checks++;
        if (dut_if.TX_OUT !== 1'b1) begin
          errors++;
          $display("FAIL idle_line tx=%b required 1 at %0t", dut_if.TX_OUT, $time);
        end
        if (in_frame) begin
          in_frame = 1'b0;
          idle_run = 1;
          last_len = cur_len;
          if (discard) begin
            discard = 1'b0;
          end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame bits=%h len=%0d required no frame", cur_bits, cur_len);
          end else begin
            frame_t e;
            e = exp_q.pop_front();
            checks++;
            if (cur_len !== e.len) begin
              errors++;
              $display("FAIL frame_len got %0d required %0d", cur_len, e.len);
            end
            checks++;
            if (cur_bits !== e.bits) begin
              errors++;
              $display("FAIL frame_bits got %h required %h", cur_bits, e.bits);
            end
            frames_done++;
          end
        end else begin
          idle_run++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic en, input logic typ, input bit expect_it);
    @(posedge CLK); #1;
    dut_if.P_DATA     = d;
    dut_if.PAR_EN     = en;
    dut_if.PAR_TYP    = typ;
    dut_if.DATA_VALID = 1'b1;
    if (expect_it) exp_q.push_back(model(d, en, typ));
    @(posedge CLK); #1;
    dut_if.DATA_VALID = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100 && frames_done < target; i++) @(negedge CLK);
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL wait_frames done=%0d required %0d", frames_done, target);
    end
  endtask

  task automatic test_reset;
    dut_if.P_DATA = '0; dut_if.DATA_VALID = 1'b0;
    dut_if.PAR_EN = 1'b0; dut_if.PAR_TYP = 1'b0;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (dut_if.TX_OUT !== 1'b1 || dut_if.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_out tx=%b busy=%b required tx=1 busy=0", dut_if.TX_OUT, dut_if.BUSY);
    end
    RST = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      checks++;
      if (dut_if.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL idle_busy busy=%b required 0", dut_if.BUSY);
      end
    end
  endtask

  task automatic test_parity_even;
    int t;
    t = frames_done + 1;
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    wait_done(t);
    checks++;
    if (last_len != 10 + STOPS) begin
      errors++;
      $display("FAIL busy_len_even got %0d required %0d", last_len, 10 + STOPS);
    end
  endtask

  task automatic test_parity_odd;
    int t;
    t = frames_done + 1;
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    wait_done(t);
  endtask

  task automatic test_no_parity;
    int t;
    t = frames_done + 1;
    send(8'hFF, 1'b0, 1'b0, 1'b1);
    wait_done(t);
    checks++;
    if (last_len != 9 + STOPS) begin
      errors++;
      $display("FAIL busy_len_nopar got %0d required %0d", last_len, 9 + STOPS);
    end
  endtask

  task automatic test_ignore_busy;
    int t, s;
    t = frames_done + 1;
    s = frames_started;
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    dut_if.P_DATA = 8'h00; dut_if.PAR_TYP = 1'b1; dut_if.PAR_EN = 1'b0;
    dut_if.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    dut_if.DATA_VALID = 1'b0;
    wait_done(t);
    repeat (15) @(negedge CLK);
    checks++;
    if (frames_started != s + 1) begin
      errors++;
      $display("FAIL dropped_word frames=%0d required %0d", frames_started - s, 1);
    end
  endtask

  task automatic test_back_to_back;
    int t, s;
    t = frames_done + 2;
    s = frames_started;
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    dut_if.DATA_VALID = 1'b1;
    dut_if.P_DATA = 8'h00; dut_if.PAR_EN = 1'b1; dut_if.PAR_TYP = 1'b1;
    exp_q.push_back(model(8'h00, 1'b1, 1'b1));
    for (int i = 0; i < 60 && frames_started < s + 2; i++) @(negedge CLK);
    @(posedge CLK); #1;
    dut_if.DATA_VALID = 1'b0;
    wait_done(t);
    checks++;
    if (last_gap != 1) begin
      errors++;
      $display("FAIL b2b_gap got %0d required 1", last_gap);
    end
  endtask

  task automatic test_reset_abort;
    int t;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge CLK);
    #2;
    discard = 1'b1;
    RST = 1'b0;
    #1;
    checks++;
    if (dut_if.TX_OUT !== 1'b1 || dut_if.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL async_abort tx=%b busy=%b required tx=1 busy=0", dut_if.TX_OUT, dut_if.BUSY);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    t = frames_done + 1;
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    wait_done(t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_frames got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
